// File: rtl/param_rb_fifo.sv
// param_rb_fifo: ring-buffer FIFO with show-ahead output, registered occupancy flags
// and sticky overflow/underflow flags.
module param_rb_fifo #(
    parameter int MSBD      = 7,
    parameter int MSBA      = 3,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [MSBD:0] dataIn,
    input  logic          push,
    input  logic          pop,
    input  logic          clrErr,
    output logic [MSBD:0] dataOut,
    output logic          full,
    output logic          empty,
    output logic          almostFull,
    output logic          almostEmpty,
    output logic [MSBA+1:0] count,
    output logic          overflow,
    output logic          underflow
);
    localparam int DEPTH = 1 << (MSBA + 1);
    localparam logic [MSBA+1:0] L_DEPTH = (MSBA + 2)'(DEPTH);
    localparam logic [MSBA+1:0] L_AF    = (MSBA + 2)'(AFULL_TH);
    localparam logic [MSBA+1:0] L_AE    = (MSBA + 2)'(AEMPTY_TH);
    localparam logic [MSBA+1:0] L_ONE   = (MSBA + 2)'(1);
    localparam logic [MSBA:0]   P_ONE   = (MSBA + 1)'(1);

    if (AFULL_TH < 0 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH > DEPTH) begin : g_bad_threshold
        $error("param_rb_fifo: threshold parameter outside 0..depth");
    end

    logic [MSBD:0]   r_mem [DEPTH];
    logic [MSBA:0]   r_head, r_tail;
    logic [MSBA+1:0] r_count;
    logic            r_full, r_empty, r_almost_full, r_almost_empty, r_overflow, r_underflow;
    logic            w_wr, w_rd;
    logic [MSBA+1:0] w_count_nxt;

    // A pop on empty is ignored, so push+pop on empty degenerates to a push; when full the pop frees the slot.
    assign w_rd        = pop && !r_empty;
    assign w_wr        = push && (!r_full || pop);
    assign w_count_nxt = (w_wr && !w_rd) ? r_count + L_ONE :
                         (w_rd && !w_wr) ? r_count - L_ONE : r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= (AFULL_TH == 0);
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr) r_head <= r_head + P_ONE;
            if (w_rd) r_tail <= r_tail + P_ONE;
            r_count        <= w_count_nxt;
            r_full         <= w_count_nxt == L_DEPTH;
            r_empty        <= w_count_nxt == '0;
            r_almost_full  <= w_count_nxt >= L_AF;
            r_almost_empty <= w_count_nxt <= L_AE;
            r_overflow     <= (push && !pop && r_full) || (r_overflow && !clrErr);
            r_underflow    <= (pop && !push && r_empty) || (r_underflow && !clrErr);
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_head] <= dataIn;
    end

    assign dataOut     = r_mem[r_tail];
    assign full        = r_full;
    assign empty       = r_empty;
    assign almostFull  = r_almost_full;
    assign almostEmpty = r_almost_empty;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
endmodule

// File: tb/tb_param_rb_fifo.sv
// tb_param_rb_fifo: scoreboard bench for param_rb_fifo at default parameters.
module tb_param_rb_fifo;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] dataIn = '0;
    logic       push = 1'b0, pop = 1'b0, clrErr = 1'b0;
    logic [7:0] dataOut;
    logic       full, empty, almostFull, almostEmpty, overflow, underflow;
    logic [4:0] count;

    int total = 0;
    int bad = 0;
    logic [7:0] q[$];
    logic m_ovf = 1'b0, m_unf = 1'b0;

    param_rb_fifo dut (
        .clock(clock), .reset_n(reset_n), .dataIn(dataIn), .push(push), .pop(pop), .clrErr(clrErr),
        .dataOut(dataOut), .full(full), .empty(empty), .almostFull(almostFull),
        .almostEmpty(almostEmpty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    // One clock of stimulus; the reference queue and sticky flags track what the FIFO must do.
    task automatic drive(input logic p, input logic r, input logic [7:0] d, input logic c);
        logic was_full, was_empty;
        push = p; pop = r; dataIn = d; clrErr = c;
        was_full  = q.size() == 16;
        was_empty = q.size() == 0;
        m_ovf = (p && !r && was_full) || (m_ovf && !c);
        m_unf = (r && !p && was_empty) || (m_unf && !c);
        if (r && !was_empty) void'(q.pop_front());
        if (p && (!was_full || r)) q.push_back(d);
        @(posedge clock);
        #1;
        push = 1'b0; pop = 1'b0; clrErr = 1'b0;
    endtask

    task automatic test_reset;
        #7;
        total++;
        if ({count, empty, full, almostEmpty, almostFull, overflow, underflow} !== {5'd0, 6'b101000}) begin
            bad++;
            $display("FAIL reset_state got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b want cnt=0 e=1 f=0 ae=1 af=0 ov=0 un=0",
                     count, empty, full, almostEmpty, almostFull, overflow, underflow);
        end
        #5 reset_n = 1'b1;
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(i + 1), 1'b0);
            total++;
            if ({count, full, empty, almostFull, almostEmpty} !== {5'(i + 1), (i == 15), 1'b0, (i >= 11), (i <= 1)}) begin
                bad++;
                $display("FAIL fill_%0d got cnt=%0d f=%b e=%b af=%b ae=%b want cnt=%0d f=%b e=0 af=%b ae=%b",
                         i, count, full, empty, almostFull, almostEmpty, i + 1, i == 15, i >= 11, i <= 1);
            end
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (dataOut !== 8'(i + 1) || dataOut !== q[0]) begin
                bad++;
                $display("FAIL drain_data_%0d got %h want %h", i, dataOut, 8'(i + 1));
            end
            drive(1'b0, 1'b1, 8'h00, 1'b0);
        end
        total++;
        if ({empty, count} !== {1'b1, 5'd0}) begin
            bad++;
            $display("FAIL drain_empty got e=%b cnt=%0d want e=1 cnt=0", empty, count);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
        drive(1'b1, 1'b0, 8'hAA, 1'b0);
        total++;
        if ({count, full, overflow} !== {5'd16, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL overflow_set got cnt=%0d f=%b ov=%b want cnt=16 f=1 ov=1", count, full, overflow);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_clear got ov=%b want 0", overflow);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (dataOut !== 8'(8'h20 + i)) begin
                bad++;
                $display("FAIL overflow_drain_%0d got %h want %h", i, dataOut, 8'(8'h20 + i));
            end
            drive(1'b0, 1'b1, 8'h00, 1'b0);
        end
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL overflow_aa_dropped got e=%b want 1", empty);
        end
    endtask

    task automatic test_underflow;
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        total++;
        if ({underflow, empty, count} !== {1'b1, 1'b1, 5'd0}) begin
            bad++;
            $display("FAIL underflow_set got un=%b e=%b cnt=%0d want un=1 e=1 cnt=0", underflow, empty, count);
        end
        drive(1'b1, 1'b1, 8'h55, 1'b0);
        total++;
        if ({count, dataOut, underflow, empty} !== {5'd1, 8'h55, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL push_pop_empty got cnt=%0d d=%h un=%b e=%b want cnt=1 d=55 un=1 e=0",
                     count, dataOut, underflow, empty);
        end
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        total++;
        if ({underflow, overflow, empty} !== {1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL underflow_clear got un=%b ov=%b e=%b want un=0 ov=0 e=1", underflow, overflow, empty);
        end
    endtask

    task automatic test_push_pop_full;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        drive(1'b1, 1'b1, 8'h77, 1'b0);
        total++;
        if ({count, full, overflow, dataOut} !== {5'd16, 1'b1, 1'b0, 8'h41}) begin
            bad++;
            $display("FAIL push_pop_full got cnt=%0d f=%b ov=%b d=%h want cnt=16 f=1 ov=0 d=41",
                     count, full, overflow, dataOut);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (dataOut !== ((i == 15) ? 8'h77 : 8'(8'h41 + i))) begin
                bad++;
                $display("FAIL full_drain_%0d got %h want %h", i, dataOut, (i == 15) ? 8'h77 : 8'(8'h41 + i));
            end
            drive(1'b0, 1'b1, 8'h00, 1'b0);
        end
    endtask

    task automatic test_wrap_random;
        int pushes = 0;
        logic p, r;
        logic [4:0] n;
        for (int i = 0; i < 40; i++) begin
            p = (i % 8 != 7) || ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 3) != 0;
            if (p && (q.size() < 16 || r)) pushes++;
            drive(p, r, 8'($urandom_range(0, 255)), 1'b0);
            n = 5'(q.size());
            total++;
            if ({count, full, empty, almostFull, almostEmpty, overflow, underflow} !==
                {n, n == 5'd16, n == 5'd0, n >= 5'd12, n <= 5'd2, m_ovf, m_unf}) begin
                bad++;
                $display("FAIL random_%0d got cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b want cnt=%0d ov=%b un=%b",
                         i, count, full, empty, almostFull, almostEmpty, overflow, underflow, n, m_ovf, m_unf);
            end
            if (q.size() > 0) begin
                total++;
                if (dataOut !== q[0]) begin
                    bad++;
                    $display("FAIL random_data_%0d got %h want %h", i, dataOut, q[0]);
                end
            end
        end
        if (pushes < 32) $display("note: only %0d pushes accepted in random phase", pushes);
    endtask

    task automatic test_reset_midstream;
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        while (q.size() > 0) drive(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
        total++;
        if (count !== 5'd5) begin
            bad++;
            $display("FAIL midstream_count got %0d want 5", count);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({empty, count, full, almostEmpty} !== {1'b1, 5'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL midstream_async_reset got e=%b cnt=%0d f=%b ae=%b want e=1 cnt=0 f=0 ae=1",
                     empty, count, full, almostEmpty);
        end
        #2 reset_n = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        drive(1'b1, 1'b0, 8'h3C, 1'b0);
        total++;
        if ({count, dataOut} !== {5'd1, 8'h3C}) begin
            bad++;
            $display("FAIL post_reset_push got cnt=%0d d=%h want cnt=1 d=3c", count, dataOut);
        end
    endtask

    initial begin
        test_reset;
        test_fill_drain;
        test_overflow;
        test_underflow;
        test_push_pop_full;
        test_wrap_random;
        test_reset_midstream;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/param_rb_fifo.md
PARAM_RB_FIFO -- requirements
Module: param_rb_fifo

Interface
REQ-001 The block SHALL have parameter MSBD, default 7: data MSB; data width is MSBD+1.
REQ-002 The block SHALL have parameter MSBA, default 3: address MSB; depth is 2^(MSBA+1) entries.
REQ-003 The block SHALL have parameter AFULL_TH, default 12: almost-full asserts when count >= AFULL_TH.
REQ-004 The block SHALL have parameter AEMPTY_TH, default 2: almost-empty asserts when count <= AEMPTY_TH.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port dataIn, input, MSBD+1 bits: write data.
REQ-008 The block SHALL have port push, input, 1 bit: write request.
REQ-009 The block SHALL have port pop, input, 1 bit: read request.
REQ-010 The block SHALL have port clrErr, input, 1 bit: synchronous clear of the sticky error flags.
REQ-011 The block SHALL have port dataOut, output, MSBD+1 bits: head-of-queue data, show-ahead.
REQ-012 The block SHALL have port full, output, 1 bit: count == depth.
REQ-013 The block SHALL have port empty, output, 1 bit: count == 0.
REQ-014 The block SHALL have port almostFull, output, 1 bit: count >= AFULL_TH.
REQ-015 The block SHALL have port almostEmpty, output, 1 bit: count <= AEMPTY_TH.
REQ-016 The block SHALL have port count, output, MSBA+2 bits: current occupancy, 0..depth.
REQ-017 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a push is dropped.
REQ-018 The block SHALL have port underflow, output, 1 bit: sticky flag, set when a pop is dropped.

Function
REQ-019 Storage SHALL be a ring buffer: head pointer = write slot, tail pointer = oldest entry; both pointers MSBA+1 bits, wrapping from depth-1 to 0 with no special case.
REQ-020 dataOut SHALL equal mem[tail] combinationally, zero cycles after the entry becomes head of queue; its value while empty is unspecified and SHALL NOT be checked.
REQ-021 A push alone with count < depth SHALL write dataIn to mem[head], increment head, and increment count.
REQ-022 A pop alone with count > 0 SHALL increment tail and decrement count.
REQ-023 Push and pop in the same cycle with 0 < count < depth SHALL perform both operations, leaving count unchanged.
REQ-024 Push and pop in the same cycle with count == depth SHALL perform both (a slot is freed and refilled), leaving count unchanged, with overflow not set.
REQ-025 Push and pop in the same cycle with count == 0 SHALL perform the push only, setting count to 1, with underflow not set; data SHALL NOT bypass to dataOut in the same cycle.
REQ-026 A push alone while full SHALL be a NOOP on memory, pointers and count, and SHALL set overflow next cycle.
REQ-027 A pop alone while empty SHALL be a NOOP and SHALL set underflow next cycle.
REQ-028 full, empty, almostFull and almostEmpty SHALL be decoded from the registered count and SHALL be glitch-free relative to clock.
REQ-029 clrErr SHALL clear overflow and underflow next cycle; if a set condition occurs in the same cycle as clrErr, set SHALL win.
REQ-030 count arithmetic SHALL use MSBA+2 bits so that depth is representable; count SHALL never exceed depth or go below 0.
REQ-031 A threshold parameter outside 0..depth SHALL be a static configuration error, flagged at elaboration.

Reset
REQ-032 While reset_n is low, asynchronously: head=0, tail=0, count=0, empty=1, full=0, almostEmpty=1, almostFull=0 (for AFULL_TH>0), overflow=0, underflow=0.
REQ-033 Memory contents SHALL NOT be reset; reset asserted mid-operation SHALL discard all queued entries immediately.
REQ-034 The first push accepted SHALL be on the first rising edge after reset_n rises.

Verification
REQ-035 The bench SHALL cover fill/drain: after reset, push 0x01..0x10 (16 pushes, default parameters) -> full=1, count=16, almostFull from count=12; then 16 pops -> data 0x01..0x10 in order, empty=1.
REQ-036 The bench SHALL cover overflow: full, then push 0xAA alone -> count stays 16, overflow=1, 0xAA never read; then clrErr -> overflow=0.
REQ-037 The bench SHALL cover underflow and the simultaneous case on empty: pop while empty -> underflow=1; push 0x55 with pop while empty -> count=1, dataOut=0x55 next cycle, underflow unchanged by that cycle.
REQ-038 The bench SHALL cover simultaneous push/pop while full: push 0x77 with pop -> count=16, dataOut advances to the second-oldest entry, 0x77 is read last.
REQ-039 The bench SHALL cover wrap-around: run 40 random interleaved push/pop cycles against a reference queue model -> dataOut, count and flags match every cycle, and pointers wrap at least twice.
REQ-040 The bench SHALL cover reset mid-stream: reset_n low with count=5 -> empty=1 and count=0 without waiting for a clock edge; the next push of 0x3C reads back as 0x3C.
